// File: rtl/fpu_tb_pkg.sv
// Shared types and helpers for the FPU per-pipeline result checking blocks.
// Holds the sink FSM encoding and the FP32 NaN classifier.
package fpu_tb_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic [1:0] {
    SINK_IDLE = 2'd0,
    SINK_RUN  = 2'd1,
    SINK_FIN  = 2'd2,
    SINK_TOUT = 2'd3
  } sink_state_e;

  function automatic logic fp32_is_nan(input logic [31:0] v);
    logic [FP32_EXP_W-1:0] e;
    logic [FP32_MAN_W-1:0] m;
    e = v[FP32_MAN_W +: FP32_EXP_W];
    m = v[FP32_MAN_W-1:0];
    return (e == '1) && (m != '0);
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Synchronous FIFO holding golden values; push while full and pop while empty are ignored.
// Flags come from the registered count only, so push never reaches empty combinationally.
module tb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_result_sink_chk.sv
// Self-checking consumer of FPU results: pops golden values in order, compares,
// counts results and mismatches, and flags completion or timeout.
module fpu_result_sink_chk
  import fpu_tb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int N_RESULTS = 16,
  parameter int TIMEOUT   = 1024,
  parameter bit NAN_EQ    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             exp_valid_i,
  input  logic [WIDTH-1:0] exp_data_i,
  output logic             exp_ready_o,
  input  logic             vin_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             rdy_o,
  output logic             mismatch_o,
  output logic [15:0]      err_cnt_o,
  output logic [15:0]      res_cnt_o,
  output logic             done_o,
  output logic             timed_out_o,
  output logic [1:0]       state_o
);

  // Handshakes: a golden value transfers on exp_valid_i && exp_ready_o, a result
  // on vin_i && rdy_o; the producer must hold data stable while valid and not ready.

  localparam logic [1:0] S_IDLE = SINK_IDLE;
  localparam logic [1:0] S_RUN  = SINK_RUN;
  localparam logic [1:0] S_FIN  = SINK_FIN;
  localparam logic [1:0] S_TOUT = SINK_TOUT;
  localparam int         IW     = $clog2(TIMEOUT) + 1;

  logic [1:0]        state_q, state_d;
  logic              init_q;
  logic [IW-1:0]     idle_q, idle_d;
  logic [15:0]       res_cnt_q, res_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              mismatch_q, mismatch_d;

  logic              fifo_full, fifo_empty;
  logic [WIDTH-1:0]  golden;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              push, accept, match, timeout_hit, last_result;
  logic [31:0]       din32, gold32;

  tb_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (exp_data_i),
    .pop_i   (accept),
    .data_o  (golden),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // init_q holds exp_ready_o low for the first cycle out of reset.
  assign exp_ready_o = init_q && !fifo_full;
  assign push        = exp_valid_i && exp_ready_o;
  assign rdy_o       = (state_q == S_RUN) && !fifo_empty;
  assign accept      = vin_i && rdy_o;

  assign din32  = 32'(din_i);
  assign gold32 = 32'(golden);

  always_comb begin
    match = (din_i == golden);
    if (NAN_EQ && (WIDTH == 32) && fp32_is_nan(din32) && fp32_is_nan(gold32))
      match = 1'b1;
  end

  assign last_result = (res_cnt_q == 16'(N_RESULTS - 1));
  assign timeout_hit = (state_q == S_RUN) && !accept && (idle_q == IW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (accept && last_result) state_d = S_FIN;
        else if (timeout_hit)      state_d = S_TOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    idle_d     = (state_q != S_RUN || accept) ? '0 : idle_q + IW'(1);
    res_cnt_d  = accept ? res_cnt_q + 16'd1 : res_cnt_q;
    mismatch_d = accept && !match;
    err_cnt_d  = err_cnt_q;
    if (mismatch_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      init_q     <= 1'b0;
      idle_q     <= '0;
      res_cnt_q  <= '0;
      err_cnt_q  <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b1;
      idle_q     <= idle_d;
      res_cnt_q  <= res_cnt_d;
      err_cnt_q  <= err_cnt_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch_o  = mismatch_q;
  assign err_cnt_o   = err_cnt_q;
  assign res_cnt_o   = res_cnt_q;
  assign done_o      = (state_q == S_FIN) || (state_q == S_TOUT);
  assign timed_out_o = (state_q == S_TOUT);
  assign state_o     = state_q;

endmodule

// File: doc/fpu_result_sink_chk.md
# fpu_result_sink_chk

Self-checking consumer for the FPU result interface in the per-pipeline testbenches. It accepts results with a valid/ready handshake and compares each one, in order, against golden values queued by the stimulus side. It counts results and mismatches, and asserts a done/timeout flag that the bench uses to end simulation. It is synthesizable so that it can also be run against the post-synthesis netlist.

## Interface
- WIDTH, 32, result and golden data width in bits.
- DEPTH, 8, golden FIFO entries; power of two, at least 2.
- N_RESULTS, 16, number of accepted results after which the check completes.
- TIMEOUT, 1024, maximum number of RUN cycles allowed between accepted results.
- NAN_EQ, 1, when 1, any NaN matches any NaN, regardless of payload or sign.
- CLK  in  1  single clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that starts checking.
- EXP_VALID  in  1  golden value valid.
- EXP_DATA  in  WIDTH  golden value.
- EXP_READY  out  1  golden FIFO can accept a value.
- VIN  in  1  result valid (driven by FPU out_valid_o).
- DIN  in  WIDTH  result (driven by FPU result_o).
- RDY  out  1  ready for a result (drives FPU out_ready_i).
- MISMATCH  out  1  one-cycle pulse when the result just checked differs from its golden value.
- ERR_CNT  out  16  mismatch count; saturates at 0xFFFF.
- RES_CNT  out  16  accepted-result count.
- DONE  out  1  check finished; sticky until reset.
- TIMED_OUT  out  1  check ended by timeout; sticky until reset.

## Operation
- States: IDLE, RUN, FIN, TOUT.
  - IDLE to RUN on START.
  - RUN to FIN when the N_RESULTS-th result is accepted.
  - RUN to TOUT when the idle counter reaches TIMEOUT-1 and no result is accepted that cycle.
  - FIN and TOUT are terminal until reset.
  - START is ignored outside IDLE.
- Golden FIFO:
  - Push on EXP_VALID && EXP_READY, in every state.
  - EXP_READY = !full. It depends only on the registered count, so there is no pass-through when the FIFO is full, even if a pop happens in the same cycle.
- Result accept:
  - RDY = (state==RUN) && !empty. There is no bypass from EXP_DATA to the compare.
  - A result is accepted on VIN && RDY. The accept pops the FIFO head and compares it with DIN.
- Compare:
  - A match is bitwise equality.
  - With NAN_EQ=1 and WIDTH=32, a value is a NaN when exponent==0xFF and mantissa!=0. Two NaNs match.
- Simultaneous push and pop: the FIFO count is unchanged. A push is legal in that cycle only if the FIFO was not full.
- Idle counter:
  - Cleared on every accept and while not in RUN.
  - Otherwise increments in RUN.
- A result that arrives while RDY=0 is not accepted. The FPU holds it under its own backpressure.

## Timing
- Reset values: EXP_READY=0 for one cycle after reset deassertion, then 1. All other outputs are 0. The FIFO is empty and the state is IDLE.
- Asserting reset mid-run clears the FIFO, counters and flags immediately (asynchronously).
- On an accept at edge k, the following are all registered and visible after edge k:
  - MISMATCH pulse;
  - ERR_CNT and RES_CNT increment;
  - FIFO pop.
- DONE:
  - Rises in the cycle after the edge that accepts the last result, together with the state change to FIN.
  - From then on RDY=0.
- TIMEOUT: TIMED_OUT and DONE both rise after exactly TIMEOUT consecutive RUN cycles with no accept.
- Throughput: one result per cycle while the FIFO is not empty.

## Structure
- Shared package fpu_tb_pkg holds:
  - the sink_state_e enum (IDLE, RUN, FIN, TOUT);
  - the fp32_is_nan function;
  - the FP32 exponent and mantissa width constants.
- Sub-module tb_sync_fifo holds the golden FIFO, parameterized by WIDTH and DEPTH, with push/pop, full/empty and a count. It has no combinational path from push to empty.
- Top level: FSM, compare, counters and the timeout logic.

## Test plan
- Queue 3 golden values (0x3F800000, 0x40000000, 0x40400000), pulse START, return matching results back to back. Required: RDY high for 3 cycles, RES_CNT=3, ERR_CNT=0, no MISMATCH.
- Golden value 0x3F800000 with result 0x3F800001. Required: MISMATCH pulses exactly one cycle after the accept, ERR_CNT=1.
- NAN_EQ=1: golden 0x7FC00000, result 0xFFC00001. Required: no mismatch. Repeat with NAN_EQ=0. Required: ERR_CNT=1.
- Fill the FIFO to DEPTH with RDY held off (before START). Required: EXP_READY=0. Then push and accept in the same cycle. Required: the push is refused and the count drops by 1.
- N_RESULTS=4, TIMEOUT=8: accept 2 results, then stop VIN. Required: TIMED_OUT=DONE=1 exactly 8 cycles after the last accept.
- Assert RST_n low mid-run, with 2 entries queued and RES_CNT=5. Required: all outputs 0 and the FIFO empty, with no clock edge needed. After release, START works again.
